// File: rtl/mini_core_mc.sv
// Multi-cycle mini core: programmable imem, 4-entry register file, ALU, load/store dmem,
// branches and halt, sequenced by an IDLE/FETCH/EXEC/MEM/HALT state machine.
module mini_core_mc #(
    parameter int DATA_W  = 8,
    parameter int NREGS   = 4,
    parameter int IMEM_AW = 4,
    parameter int DMEM_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [IMEM_AW-1:0] prog_addr,
    input  logic [15:0]        prog_data,
    input  logic               start,
    output logic               busy,
    output logic               halted,
    output logic               retire,
    output logic [IMEM_AW-1:0] pc_o,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LDI  = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_BEQZ = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    state_t              state, state_nxt;
    logic [IMEM_AW-1:0]  pc;
    logic [15:0]         ir;
    logic [15:0]         imem [2**IMEM_AW];
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   dmem [2**DMEM_AW];

    logic [3:0]          op;
    logic [1:0]          rd, rs1, rs2;
    logic [7:0]          imm8;
    logic [DATA_W-1:0]   rs1_val, rs2_val, imm_ext, alu_res;
    logic [DMEM_AW-1:0]  daddr;
    logic [IMEM_AW-1:0]  target;

    assign op      = ir[15:12];
    assign rd      = ir[11:10];
    assign rs1     = ir[9:8];
    assign rs2     = ir[7:6];
    assign imm8    = ir[7:0];
    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign imm_ext = DATA_W'(imm8);
    assign daddr   = rs1_val[DMEM_AW-1:0];
    assign target  = imm8[IMEM_AW-1:0];

    assign pc_o     = pc;
    assign dbg_data = regs[dbg_sel];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = rs1_val + rs2_val;
            OP_SUB:  alu_res = rs1_val - rs2_val;
            OP_AND:  alu_res = rs1_val & rs2_val;
            OP_OR:   alu_res = rs1_val | rs2_val;
            OP_XOR:  alu_res = rs1_val ^ rs2_val;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (op == OP_LD)        state_nxt = S_MEM;
                else if (op == OP_HALT) state_nxt = S_HALT;
                else                    state_nxt = S_FETCH;
            end
            S_MEM:   state_nxt = S_FETCH;
            S_HALT:  if (start) state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM);
        halted = (state == S_HALT);
        retire = ((state == S_EXEC) && (op != OP_LD)) || (state == S_MEM);
    end

    // NOTE: imem has no reset so a loaded program survives rst; dmem and regs are cleared.
    always_ff @(posedge clk) begin
        if (prog_we && (state == S_IDLE || state == S_HALT))
            imem[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
            for (int i = 0; i < NREGS; i++)      regs[i] <= '0;
            for (int i = 0; i < 2**DMEM_AW; i++) dmem[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT: if (start) pc <= '0;
                S_FETCH: ir <= imem[pc];
                S_EXEC: begin
                    pc <= pc + 1'b1;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: regs[rd] <= alu_res;
                        OP_LDI:  regs[rd] <= imm_ext;
                        OP_ST:   dmem[daddr] <= rs2_val;
                        OP_BEQZ: if (rs1_val == '0) pc <= target;
                        OP_JMP:  pc <= target;
                        OP_HALT: pc <= pc;
                        default: ;
                    endcase
                end
                // Load data is written back one cycle after the address is presented.
                S_MEM: regs[rd] <= dmem[daddr];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_core_mc.sv
// Self-checking bench for mini_core_mc: directed programs plus random straight-line programs,
// all compared against an instruction-level interpreter of the ISA.
module tb_mini_core_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        start = 1'b0;
    logic [1:0]  dbg_sel = '0;
    logic        busy, halted, retire;
    logic [3:0]  pc_o;
    logic [7:0]  dbg_data;
    logic        busy16, halted16, retire16;
    logic [3:0]  pc16;
    logic [15:0] dbg_data16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_imem [16];
    logic [7:0]  m_regs [4];
    logic [7:0]  m_dmem [16];

    mini_core_mc #(.DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .busy(busy), .halted(halted), .retire(retire), .pc_o(pc_o),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    mini_core_mc #(.DATA_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .busy(busy16), .halted(halted16), .retire(retire16), .pc_o(pc16),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int a, input int b);
        return {4'(op), 2'(rd), 2'(a), 2'(b), 6'd0};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int a, input int imm);
        return {4'(op), 2'(rd), 2'(a), 8'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++)  m_regs[i] = '0;
        for (int i = 0; i < 16; i++) m_dmem[i] = '0;
    endtask

    // Instruction-level interpreter: each instruction costs 2 cycles, loads 3.
    task automatic model_run(output int cyc, output int ret, output bit hlt);
        int pc, rd, a, b;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [7:0]  va, vb, imm;
        pc = 0; cyc = 0; ret = 0; hlt = 0;
        for (int n = 0; n < 100 && !hlt; n++) begin
            ins = m_imem[pc];
            op  = ins[15:12];
            rd  = int'(ins[11:10]);
            a   = int'(ins[9:8]);
            b   = int'(ins[7:6]);
            imm = ins[7:0];
            va  = m_regs[a];
            vb  = m_regs[b];
            ret++;
            cyc += (op == 4'd6) ? 3 : 2;
            pc = (pc + 1) % 16;
            case (op)
                4'd0: m_regs[rd] = va + vb;
                4'd1: m_regs[rd] = va - vb;
                4'd2: m_regs[rd] = va & vb;
                4'd3: m_regs[rd] = va | vb;
                4'd4: m_regs[rd] = va ^ vb;
                4'd5: m_regs[rd] = imm;
                4'd6: m_regs[rd] = m_dmem[va % 16];
                4'd7: m_dmem[va % 16] = vb;
                4'd8: if (va == 0) pc = imm % 16;
                4'd9: pc = imm % 16;
                4'd15: hlt = 1;
                default: ;
            endcase
        end
    endtask

    task automatic load_prog(input logic [15:0] words [$]);
        foreach (words[i]) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_data = words[i];
            m_imem[i] = words[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic dut_run(output int cyc, output int ret);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; ret = 0;
        while (!halted && cyc < 400) begin
            if (retire) ret++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_and_check(input string tag);
        int mc, mr, dc, dr;
        bit mh;
        model_run(mc, mr, mh);
        dut_run(dc, dr);
        check({tag, "_halted"}, 32'(halted), 32'(mh));
        check({tag, "_cycles"}, 32'(dc), 32'(mc));
        check({tag, "_retires"}, 32'(dr), 32'(mr));
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            check($sformatf("%s_r%0d", tag, r), 32'(dbg_data), 32'(m_regs[r]));
        end
    endtask

    initial begin
        logic [15:0] prog [$];
        int k;
        for (int i = 0; i < 16; i++) m_imem[i] = '0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_retire", 32'(retire), 0);
        check("rst_pc", 32'(pc_o), 0);
        check("rst_r0", 32'(dbg_data), 0);
        rst = 1'b0;

        prog = '{enc_i(5, 0, 0, 5), enc_i(5, 1, 0, 3), enc_r(0, 2, 0, 1), enc_i(15, 0, 0, 0)};
        load_prog(prog);
        run_and_check("add");
        dbg_sel = 2'd2; #1;
        check("add_r2_const", 32'(dbg_data), 8);
        check("add_r2_w16", 32'(dbg_data16), 8);

        prog = '{enc_i(5, 0, 0, 5), enc_i(5, 1, 0, 3), enc_r(1, 2, 1, 0), enc_i(15, 0, 0, 0)};
        load_prog(prog);
        run_and_check("sub");
        dbg_sel = 2'd2; #1;
        check("sub_w8", 32'(dbg_data), 32'h00FE);
        check("sub_w16", 32'(dbg_data16), 32'hFFFE);

        prog = '{enc_i(5, 0, 0, 2), enc_i(5, 1, 0, 8'h5A), enc_r(7, 0, 0, 1), enc_r(6, 3, 0, 0),
                 enc_i(15, 0, 0, 0)};
        load_prog(prog);
        run_and_check("stld");
        dbg_sel = 2'd3; #1;
        check("stld_r3", 32'(dbg_data), 32'h5A);

        prog = '{enc_i(5, 0, 0, 3), enc_i(5, 1, 0, 1), enc_r(1, 0, 0, 1), enc_i(8, 0, 0, 5),
                 enc_i(9, 0, 0, 2), enc_i(15, 0, 0, 0)};
        load_prog(prog);
        run_and_check("loop");
        dbg_sel = 2'd0; #1;
        check("loop_r0", 32'(dbg_data), 0);

        for (int t = 0; t < 6; t++) begin
            int op;
            prog = {};
            for (int i = 0; i < 15; i++) begin
                op = int'($urandom_range(0, 12));
                if (op > 7) op = op + 2;
                if (op == 5) prog.push_back(enc_i(5, $urandom_range(0, 3), 0, $urandom_range(0, 255)));
                else prog.push_back(enc_r(op, $urandom_range(0, 3), $urandom_range(0, 3),
                                          $urandom_range(0, 3)));
            end
            prog.push_back(enc_i(15, 0, 0, 0));
            load_prog(prog);
            run_and_check($sformatf("rand%0d", t));
        end

        prog = '{enc_i(5, 0, 0, 5), enc_i(5, 1, 0, 3), enc_r(0, 2, 0, 1), enc_i(15, 0, 0, 0)};
        load_prog(prog);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        k = 0;
        while (!retire && k < 20) begin @(posedge clk); #1; k++; end
        check("midrst_reached_exec", 32'(retire), 1);
        rst = 1'b1; #1;
        model_reset();
        check("midrst_busy", 32'(busy), 0);
        check("midrst_halted", 32'(halted), 0);
        check("midrst_retire", 32'(retire), 0);
        check("midrst_pc", 32'(pc_o), 0);
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            check($sformatf("midrst_r%0d", r), 32'(dbg_data), 0);
        end
        @(negedge clk); rst = 1'b0;
        run_and_check("rerun");

        prog = {};
        for (int i = 0; i < 16; i++) prog.push_back(enc_i(10, 0, 0, 0));
        load_prog(prog);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check($sformatf("nop_pc_c%0d", c), 32'(pc_o), 32'((c / 2) % 16));
            check($sformatf("nop_busy_c%0d", c), 32'(busy), 1);
            prog_we = (c == 4);
            prog_addr = 4'd3;
            prog_data = enc_i(15, 0, 0, 0);
            start = (c == 10);
            @(posedge clk); #1;
        end
        prog_we = 1'b0; start = 1'b0;
        rst = 1'b1; #1;
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("busy_write_ignored_halted", 32'(halted), 0);
        check("busy_write_ignored_pc", 32'(pc_o), 4);
        rst = 1'b1; #1;
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
